// File: rtl/pipe_stage_pkg.sv
// Shared types for the pipeline stage registers: FSM state and the packed
// payload words carried across each stage boundary (size DATA_W with $bits).
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used for stall counting, reusable for other performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional two-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
//
// state | meaning
// EMPTY | no live entry, out_valid=0
// BUSY  | main holds the head entry
// FULL  | main holds head, skid holds the next entry; upstream is blocked
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic              w_accept;
    logic              w_drain;
    logic              w_load_main;
    logic              w_main_from_skid;
    logic              w_load_skid;
    logic              w_stall;

    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    // Skid mode breaks the out_ready -> in_ready path with a flop.
    assign in_ready  = SKID_EN ? r_in_ready : (out_ready | ~out_valid);
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;
    assign w_stall   = out_valid & ~out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_load_main = 1'b1;
                        w_state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (w_accept && w_drain) begin
                        w_load_main = 1'b1;
                    end else if (w_accept && SKID_EN) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = FULL;
                    end else if (w_drain) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = BUSY;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : in_data;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (w_stall),
        .clr  (clr_cnt),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: dut A (skid, 16-bit counter) and dut B (no skid,
// 2-bit counter) checked against a FIFO-occupancy reference model.
module tb_pipe_stage_reg;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr_cnt;
    logic [31:0] a_in_data, a_out_data;
    logic [15:0] a_stall_cnt;
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr_cnt;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: ordered list of live entries plus the stall count.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b1), .CNT_W(16)) u_dut_a (
        .CLK(CLK), .nRST(nRST), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .clr_cnt(a_clr_cnt), .stall_cnt(a_stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b0), .CNT_W(2)) u_dut_b (
        .CLK(CLK), .nRST(nRST), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .clr_cnt(b_clr_cnt), .stall_cnt(b_stall_cnt)
    );

    task automatic model_reset();
        qa.delete();
        qb.delete();
        cnt_a = '0;
        cnt_b = '0;
    endtask

    task automatic model_edge();
        bit va, ra, vb, rb;
        va = (qa.size() > 0);
        ra = (qa.size() < 2);
        vb = (qb.size() > 0);
        rb = b_out_ready || (qb.size() == 0);
        if (a_clr_cnt) cnt_a = '0;
        else if (va && !a_out_ready && cnt_a != 16'hFFFF) cnt_a = cnt_a + 16'd1;
        if (b_clr_cnt) cnt_b = '0;
        else if (vb && !b_out_ready && cnt_b != 2'd3) cnt_b = cnt_b + 2'd1;
        if (a_flush) qa.delete();
        else begin
            if (va && a_out_ready) void'(qa.pop_front());
            if (a_in_valid && ra) qa.push_back(a_in_data);
        end
        if (b_flush) qb.delete();
        else begin
            if (vb && b_out_ready) void'(qb.pop_front());
            if (b_in_valid && rb) qb.push_back(b_in_data);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_all();
        a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_clr_cnt = 0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_clr_cnt = 0; b_in_data = '0;
    endtask

    task automatic settle();
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_all();
        model_reset();
        #23;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_a_valid got=%0h exp=0", a_out_valid); end
        checks++; if (a_out_data !== 32'h0) begin failures++; $display("FAIL rst_a_data got=%0h exp=0", a_out_data); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_a_ready got=%0h exp=1", a_in_ready); end
        checks++; if (a_stall_cnt !== 16'h0) begin failures++; $display("FAIL rst_a_cnt got=%0h exp=0", a_stall_cnt); end
        checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL rst_b_valid got=%0h exp=0", b_out_valid); end
        checks++; if (b_out_data !== 32'h0) begin failures++; $display("FAIL rst_b_data got=%0h exp=0", b_out_data); end
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL rst_b_ready got=%0h exp=1", b_in_ready); end
        checks++; if (b_stall_cnt !== 2'h0) begin failures++; $display("FAIL rst_b_cnt got=%0h exp=0", b_stall_cnt); end
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #2;
    endtask

    task automatic test_latency();
        a_in_valid = 1; a_in_data = 32'hDEADBEEF; a_out_ready = 1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL lat_ready got=%0h exp=1", a_in_ready); end
        tick();
        a_in_valid = 0;
        #1;
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%0h exp=1", a_out_valid); end
        checks++; if (a_out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lat_data got=%0h exp=deadbeef", a_out_data); end
        tick();
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL lat_empty got=%0h exp=0", a_out_valid); end
        settle();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1; a_in_data = i; a_out_ready = 1;
            b_in_valid = 1; b_in_data = i; b_out_ready = 1;
            #1;
            checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL stream_a_ready i=%0d got=%0h exp=1", i, a_in_ready); end
            checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL stream_b_ready i=%0d got=%0h exp=1", i, b_in_ready); end
            if (i > 1) begin
                checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'(i - 1)) begin failures++; $display("FAIL stream_a_data got=%0h/%0h exp=1/%0h", a_out_valid, a_out_data, i - 1); end
                checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'(i - 1)) begin failures++; $display("FAIL stream_b_data got=%0h/%0h exp=1/%0h", b_out_valid, b_out_data, i - 1); end
            end
            tick();
        end
        a_in_valid = 0; b_in_valid = 0;
        #1;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h8) begin failures++; $display("FAIL stream_a_last got=%0h/%0h exp=1/8", a_out_valid, a_out_data); end
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h8) begin failures++; $display("FAIL stream_b_last got=%0h/%0h exp=1/8", b_out_valid, b_out_data); end
        settle();
    endtask

    task automatic test_skid();
        a_in_valid = 1; a_in_data = 32'hA; a_out_ready = 1;
        tick();
        a_in_data = 32'hB; a_out_ready = 0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_before got=%0h exp=1", a_in_ready); end
        tick();
        a_in_valid = 0;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL skid_ready_full got=%0h exp=0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hA) begin failures++; $display("FAIL skid_hold got=%0h/%0h exp=1/a", a_out_valid, a_out_data); end
        tick();
        #1;
        checks++; if (a_out_data !== 32'hA) begin failures++; $display("FAIL skid_stable got=%0h exp=a", a_out_data); end
        a_out_ready = 1;
        tick();
        #1;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hB) begin failures++; $display("FAIL skid_second got=%0h/%0h exp=1/b", a_out_valid, a_out_data); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_again got=%0h exp=1", a_in_ready); end
        tick();
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL skid_empty got=%0h exp=0", a_out_valid); end
        settle();
    endtask

    task automatic test_flush();
        a_in_valid = 1; a_in_data = 32'hA; a_out_ready = 1;
        tick();
        a_in_data = 32'hB; a_out_ready = 0;
        tick();
        a_flush = 1; a_in_data = 32'hC;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL flush_full_ready got=%0h exp=0", a_in_ready); end
        tick();
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_valid got=%0h exp=0", a_out_valid); end
        a_in_valid = 1; a_in_data = 32'hA; a_out_ready = 0;
        tick();
        a_flush = 1; a_in_data = 32'hC;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_busy_ready got=%0h exp=1", a_in_ready); end
        tick();
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_busy_valid k=%0d got=%0h/%0h exp=0", k, a_out_valid, a_out_data); end
            tick();
        end
        settle();
    endtask

    task automatic test_counter();
        a_clr_cnt = 1; a_in_valid = 1; a_in_data = 32'h77; a_out_ready = 1;
        b_clr_cnt = 1; b_in_valid = 1; b_in_data = 32'h99; b_out_ready = 1;
        tick();
        a_clr_cnt = 0; a_in_valid = 0; a_out_ready = 0;
        b_clr_cnt = 0; b_in_valid = 0; b_out_ready = 0;
        repeat (5) tick();
        #1;
        checks++; if (a_stall_cnt !== 16'd5) begin failures++; $display("FAIL cnt_a_five got=%0d exp=5", a_stall_cnt); end
        tick();
        #1;
        checks++; if (b_stall_cnt !== 2'd3) begin failures++; $display("FAIL cnt_b_sat got=%0d exp=3", b_stall_cnt); end
        checks++; if (b_out_data !== 32'h99) begin failures++; $display("FAIL cnt_b_hold got=%0h exp=99", b_out_data); end
        a_clr_cnt = 1; b_clr_cnt = 1;
        tick();
        a_clr_cnt = 0; b_clr_cnt = 0; a_out_ready = 1; b_out_ready = 1;
        #1;
        checks++; if (a_stall_cnt !== 16'd0) begin failures++; $display("FAIL cnt_a_clr got=%0d exp=0", a_stall_cnt); end
        checks++; if (b_stall_cnt !== 2'd0) begin failures++; $display("FAIL cnt_b_clr got=%0d exp=0", b_stall_cnt); end
        settle();
    endtask

    task automatic test_noskid();
        b_in_valid = 1; b_in_data = 32'h11; b_out_ready = 1;
        tick();
        b_in_data = 32'h22; b_out_ready = 0;
        #1;
        checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL noskid_blocked got=%0h exp=0", b_in_ready); end
        b_out_ready = 1;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL noskid_open got=%0h exp=1", b_in_ready); end
        tick();
        b_in_valid = 0;
        #1;
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h22) begin failures++; $display("FAIL noskid_data got=%0h/%0h exp=1/22", b_out_valid, b_out_data); end
        settle();
    endtask

    task automatic test_reset_mid();
        a_in_valid = 1; a_in_data = 32'h5; a_out_ready = 0;
        tick();
        a_in_data = 32'h6;
        tick();
        a_in_valid = 0;
        #1;
        nRST = 1'b0;
        #1;
        model_reset();
        checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h0) begin failures++; $display("FAIL midrst_out got=%0h/%0h exp=0/0", a_out_valid, a_out_data); end
        checks++; if (a_in_ready !== 1'b1 || a_stall_cnt !== 16'h0) begin failures++; $display("FAIL midrst_ready_cnt got=%0h/%0h exp=1/0", a_in_ready, a_stall_cnt); end
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #2;
        a_in_valid = 1; a_in_data = 32'h55; a_out_ready = 1;
        tick();
        a_in_valid = 0;
        #1;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h55) begin failures++; $display("FAIL midrst_first got=%0h/%0h exp=1/55", a_out_valid, a_out_data); end
        settle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            a_in_valid = ($urandom_range(0, 3) != 0);
            a_in_data = $urandom;
            a_out_ready = ($urandom_range(0, 1) != 0);
            a_flush = ($urandom_range(0, 19) == 0);
            a_clr_cnt = ($urandom_range(0, 29) == 0);
            b_in_valid = ($urandom_range(0, 3) != 0);
            b_in_data = $urandom;
            b_out_ready = ($urandom_range(0, 1) != 0);
            b_flush = ($urandom_range(0, 19) == 0);
            b_clr_cnt = ($urandom_range(0, 29) == 0);
            #1;
            checks++; if (a_in_ready !== (qa.size() < 2)) begin failures++; $display("FAIL rnd_a_ready n=%0d got=%0h exp=%0h", n, a_in_ready, qa.size() < 2); end
            checks++; if (a_out_valid !== (qa.size() > 0)) begin failures++; $display("FAIL rnd_a_valid n=%0d got=%0h exp=%0h", n, a_out_valid, qa.size() > 0); end
            if (qa.size() > 0) begin
                checks++; if (a_out_data !== qa[0]) begin failures++; $display("FAIL rnd_a_data n=%0d got=%0h exp=%0h", n, a_out_data, qa[0]); end
            end
            checks++; if (a_stall_cnt !== cnt_a) begin failures++; $display("FAIL rnd_a_cnt n=%0d got=%0d exp=%0d", n, a_stall_cnt, cnt_a); end
            checks++; if (b_in_ready !== (b_out_ready || qb.size() == 0)) begin failures++; $display("FAIL rnd_b_ready n=%0d got=%0h exp=%0h", n, b_in_ready, b_out_ready || qb.size() == 0); end
            checks++; if (b_out_valid !== (qb.size() > 0)) begin failures++; $display("FAIL rnd_b_valid n=%0d got=%0h exp=%0h", n, b_out_valid, qb.size() > 0); end
            if (qb.size() > 0) begin
                checks++; if (b_out_data !== qb[0]) begin failures++; $display("FAIL rnd_b_data n=%0d got=%0h exp=%0h", n, b_out_data, qb[0]); end
            end
            checks++; if (b_stall_cnt !== cnt_b) begin failures++; $display("FAIL rnd_b_cnt n=%0d got=%0d exp=%0d", n, b_stall_cnt, cnt_b); end
            tick();
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_streaming();
        test_skid();
        test_flush();
        test_counter();
        test_noskid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register. It generalises the fixed IF/ID/EX/MEM latch set to an arbitrary-width payload with valid/ready flow control, synchronous flush, an optional skid buffer, and a saturating stall-cycle counter. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), carrying that boundary's packed control-plus-data word.

## Interface
- DATA_W, 32, payload width in bits (≥1)
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational ready
- CNT_W, 16, stall counter width (≥1)

- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries (branch/jump squash)
- in_valid  in  1  upstream presents in_data
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data holds a live entry
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  head payload
- clr_cnt  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating

## Operation
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- SKID_EN=1 state machine, states EMPTY / BUSY / FULL:
  - EMPTY: accept → main<=in_data, BUSY; otherwise stay.
  - BUSY: accept & drain → main<=in_data, stay BUSY; accept & !drain → skid<=in_data, FULL; !accept & drain → EMPTY; neither → hold.
  - FULL: in_ready=0; drain → main<=skid, BUSY; otherwise hold.
  - in_ready = (state != FULL), taken from a flop, with no combinational path from out_ready.
- SKID_EN=0: main register only; in_ready = out_ready | !out_valid, which is combinational. FULL is unreachable.
- out_valid = (state != EMPTY); out_data = main.
- flush has highest priority. The next state is EMPTY regardless of accept or drain. Data accepted in the flush cycle is discarded, and upstream treats it as consumed. A drain in the flush cycle still counts as delivered.
- A bubble is an out_valid=0 cycle. Hazard logic inserts one by holding out_ready=0 upstream or deasserting in_valid. The stage never fabricates data.
- stall_cnt increments when out_valid & !out_ready, saturates at 2^CNT_W−1, and is unaffected by flush. If clr_cnt and an increment coincide, stall_cnt goes to 0.

## Timing
- Reset (nRST=0, asynchronous): state EMPTY, out_valid=0, out_data=0, skid=0, stall_cnt=0. in_ready=1 with SKID_EN=1; with SKID_EN=0, in_ready=1 because out_valid=0.
- Latency: accepted data appears on out_data with out_valid=1 on the next rising edge (1 cycle).
- Throughput: 1 entry/cycle sustained while out_ready=1, in both modes.
- Backpressure, SKID_EN=1: in_ready falls one cycle after the first stalled accept. At most 2 entries are held; no entry is lost or duplicated.
- Order: strict FIFO. The skid entry is always delivered after main.
- nRST asserted mid-transfer discards all entries immediately. The first accept after release is delivered normally.
- out_data changes only on an edge where main loads; it is stable while out_valid & !out_ready.

## Structure
- pipe_stage_pkg: typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_t. Stage payload structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t) live there too, so callers set DATA_W = $bits(struct).
- One sub-module, sat_counter #(CNT_W) (inc, clr, count), implements stall_cnt and is reusable for other performance counters.
- Data path and FSM in a single always_ff with asynchronous nRST; next-state logic in always_comb.

## Test plan
- Reset and latency: release nRST, then in_valid=1, in_data=0xDEADBEEF, out_ready=1. Required: out_valid=1 with out_data=0xDEADBEEF one cycle later; all outputs match reset values while nRST=0.
- Streaming: push 0x1..0x8 on consecutive cycles with out_ready=1. Required: 0x1..0x8 appear on consecutive cycles and in_ready stays 1.
- Skid (SKID_EN=1): BUSY holding 0xA, drop out_ready, accept 0xB. Required: in_ready=0 next cycle, out_data stays 0xA. Raise out_ready. Required: 0xA then 0xB, in_ready=1 again.
- Flush: FULL holding 0xA/0xB, assert flush with in_valid=1, in_data=0xC. Required: out_valid=0 next cycle, and 0xC is never output.
- Counter: hold out_valid=1, out_ready=0 for 5 cycles. Required: stall_cnt=5. With CNT_W=2, hold for 6 cycles. Required: stall_cnt saturates at 3. clr_cnt → 0.
- SKID_EN=0: with out_valid=1 and out_ready=0, required in_ready=0 in the same cycle. Raise out_ready. Required: in_ready=1 in the same cycle.
